// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - bitstream loader/verifier driving the fabric configuration chain
//
// Accepts bitstream bytes over valid/ready and shifts them MSB-first onto the
// configuration chain head. It raises a per-cycle chain shift enable while doing so.
// A verify pass re-shifts the same stream. It then compares the CRC of the bits
// returning on the chain tail against the CRC of the bits sent.
//
// Ports:
//   prog_clk_i      configuration clock (only clock)
//   prog_reset_i    asynchronous active-high reset
//   start_i         1-cycle pulse, begins a pass from IDLE or DONE
//   verify_i        sampled with start_i: 0 = load pass, 1 = verify pass
//   s_data_i        bitstream byte, bit 7 shifted first
//   s_valid_i       s_data_i valid
//   s_ready_o       byte accepted this cycle when s_valid_i is also high
//   ccff_head_o     serial bit into the chain
//   ccff_tail_i     serial bit leaving the chain end
//   chain_clk_en_o  chain shifts on the clock edge ending this cycle
//   busy_o          pass in progress
//   done_o          pass complete, held until the next accepted start
//   verify_ok_o     last verify pass matched; always 0 after a load pass
//   crc_o           CRC-16-CCITT of the bits driven on ccff_head_o this pass
module ccff_bitstream_loader #(
    parameter int  CHAIN_LEN = 4096,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic        prog_clk_i,
    input  logic        prog_reset_i,
    input  logic        start_i,
    input  logic        verify_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic        ccff_head_o,
    input  logic        ccff_tail_i,
    output logic        chain_clk_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        verify_ok_o,
    output logic [15:0] crc_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_head_q, crc_head_d;
    logic [15:0]      crc_tail_q, crc_tail_d;
    logic             verify_lat_q, verify_lat_d;
    logic             verify_ok_q, verify_ok_d;

    // Bit-serial CRC-16-CCITT (poly 0x1021, MSB first, no reflection).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge prog_clk_i or posedge prog_reset_i) begin
        if (prog_reset_i) begin
            state_q      <= ST_IDLE;
            byte_q       <= 8'h00;
            bit_q        <= 3'd0;
            cnt_q        <= '0;
            crc_head_q   <= CRC_INIT;
            crc_tail_q   <= CRC_INIT;
            verify_lat_q <= 1'b0;
            verify_ok_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            crc_head_q   <= crc_head_d;
            crc_tail_q   <= crc_tail_d;
            verify_lat_q <= verify_lat_d;
            verify_ok_q  <= verify_ok_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        byte_d         = byte_q;
        bit_d          = bit_q;
        cnt_d          = cnt_q;
        crc_head_d     = crc_head_q;
        crc_tail_d     = crc_tail_q;
        verify_lat_d   = verify_lat_q;
        verify_ok_d    = verify_ok_q;
        s_ready_o      = 1'b0;
        ccff_head_o    = 1'b0;
        chain_clk_en_o = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done_o = (state_q == ST_DONE);
                if (start_i) begin
                    state_d      = ST_FETCH;
                    cnt_d        = '0;
                    crc_head_d   = CRC_INIT;
                    crc_tail_d   = CRC_INIT;
                    verify_lat_d = verify_i;
                    verify_ok_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                busy_o    = 1'b1;
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    byte_d  = s_data_i;
                    bit_d   = 3'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The current bit is always byte_q[7]; the byte shifts left under it.
                busy_o         = 1'b1;
                chain_clk_en_o = 1'b1;
                ccff_head_o    = byte_q[7];
                byte_d         = {byte_q[6:0], 1'b0};
                bit_d          = bit_q + 3'd1;
                cnt_d          = cnt_q + CNT_W'(1);
                crc_head_d     = crc_step(crc_head_q, byte_q[7]);
                // Tail is sampled in the same cycle as the shift, i.e. before the edge moves it.
                if (verify_lat_q) begin
                    crc_tail_d = crc_step(crc_tail_q, ccff_tail_i);
                end
                // The chain end takes priority, so the unused low bits of the last byte are dropped.
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_CHECK;
                end else if (bit_q == 3'd7) begin
                    state_d = ST_FETCH;
                end
            end
            ST_CHECK: begin
                busy_o      = 1'b1;
                verify_ok_d = verify_lat_q && (crc_tail_q == crc_head_q);
                state_d     = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign verify_ok_o = verify_ok_q;
    assign crc_o       = crc_head_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - self-checking bench for ccff_bitstream_loader with a behavioural chain
module tb_ccff_bitstream_loader;

    localparam int CL = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        vfy = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready, head, tail, en, busy, done, vok;
    logic [15:0] crc;

    ccff_bitstream_loader #(.CHAIN_LEN(CL)) dut (
        .prog_clk_i     (clk),
        .prog_reset_i   (rst),
        .start_i        (start),
        .verify_i       (vfy),
        .s_data_i       (s_data),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .ccff_head_o    (head),
        .ccff_tail_i    (tail),
        .chain_clk_en_o (en),
        .busy_o         (busy),
        .done_o         (done),
        .verify_ok_o    (vok),
        .crc_o          (crc)
    );

    always #5 clk = ~clk;

    // Behavioural chain: new bit enters at index 0, tail is the top index.
    logic [CL-1:0] chain = '0;
    int            sh_cnt = 0;
    bit            flip_en = 1'b0;
    int            flip_abs = 0;

    always @(posedge clk) begin
        if (en) begin
            chain  <= {chain[CL-2:0], head};
            sh_cnt <= sh_cnt + 1;
        end
    end

    assign tail = chain[CL-1] ^ (flip_en && (sh_cnt == flip_abs));

    bit head_q[$];
    bit tail_q[$];

    always @(negedge clk) begin
        if (en) begin
            head_q.push_back(head);
            tail_q.push_back(tail);
        end
    end

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] bytes[$];
    int         hs_cnt;

    // Stream vector with element 0 of the stream at bit CL-1.
    function automatic logic [CL-1:0] q2v(input bit q[$]);
        logic [CL-1:0] v = '0;
        for (int i = 0; i < CL; i++) begin
            if (i < q.size()) v[CL-1-i] = q[i];
        end
        return v;
    endfunction

    function automatic logic [CL-1:0] exp_vec();
        logic [CL-1:0] v = '0;
        logic [7:0]    b;
        for (int i = 0; i < CL; i++) begin
            b = bytes[i/8];
            v[CL-1-i] = b[7 - (i % 8)];
        end
        return v;
    endfunction

    function automatic logic [15:0] crc_ref(input logic [CL-1:0] v);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        for (int i = CL - 1; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic set_ref_bytes();
        bytes.delete();
        bytes.push_back(8'hA5);
        bytes.push_back(8'h3C);
        bytes.push_back(8'hFF);
    endtask

    task automatic run_pass(input bit v, input int stall_byte, input int stall_cyc, input bit glitch);
        int idx = 0;
        int cycles = 0;
        int stall_left = stall_cyc;
        bit glitched = 1'b0;
        @(negedge clk);
        start = 1'b1;
        vfy   = v;
        @(negedge clk);
        start = 1'b0;
        head_q.delete();
        tail_q.delete();
        hs_cnt = 0;
        while (!done && cycles < 2000) begin
            start = 1'b0;
            if (idx == stall_byte && stall_left > 0 && (s_ready || stall_left < stall_cyc)) begin
                s_valid = 1'b0;
                stall_left--;
                n_checks++;
                if (s_ready !== 1'b1 || en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_freeze: s_ready=%b en=%b required s_ready=1 en=0", s_ready, en);
                end
            end else begin
                s_valid = (idx < bytes.size());
                s_data  = s_valid ? bytes[idx] : 8'h00;
                if (s_ready && s_valid) begin
                    idx++;
                    hs_cnt++;
                end
            end
            if (glitch && !glitched && en) begin
                start    = 1'b1;
                glitched = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_timeout: done=%b after %0d cycles, required 1", done, cycles);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s_ready, head, en, busy, done, vok, crc} !== {6'b0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL reset_state: got %b_%h required 000000_ffff",
                     {s_ready, head, en, busy, done, vok}, crc);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_ready, en, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b required 0000", {s_ready, en, busy, done});
        end
    endtask

    logic [CL-1:0] load_head;
    logic [15:0]   load_crc;
    logic [CL-1:0] load_chain;

    task automatic test_load();
        set_ref_bytes();
        run_pass(1'b0, -1, 0, 1'b0);
        load_head  = q2v(head_q);
        load_crc   = crc;
        load_chain = chain;
        n_checks++;
        if (head_q.size() != CL) begin
            n_fail++;
            $display("FAIL load_en_cycles: got %0d required %0d", head_q.size(), CL);
        end
        n_checks++;
        if (load_head !== 22'b1010_0101_0011_1100_1111_11) begin
            n_fail++;
            $display("FAIL load_head_seq: got %b required 1010010100111100111111", load_head);
        end
        n_checks++;
        if (hs_cnt != 3) begin
            n_fail++;
            $display("FAIL load_handshakes: got %0d required 3", hs_cnt);
        end
        n_checks++;
        if ({done, vok, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL load_status: done/vok/busy got %b required 100", {done, vok, busy});
        end
        n_checks++;
        if (crc !== crc_ref(exp_vec())) begin
            n_fail++;
            $display("FAIL load_crc: got %h required %h", crc, crc_ref(exp_vec()));
        end
        n_checks++;
        if (chain !== exp_vec()) begin
            n_fail++;
            $display("FAIL load_chain_order: got %b required %b", chain, exp_vec());
        end
    endtask

    task automatic test_verify();
        set_ref_bytes();
        run_pass(1'b1, -1, 0, 1'b0);
        n_checks++;
        if (q2v(tail_q) !== load_head || tail_q.size() != CL) begin
            n_fail++;
            $display("FAIL verify_tail_stream: got %b (%0d bits) required %b", q2v(tail_q), tail_q.size(), load_head);
        end
        n_checks++;
        if (vok !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL verify_ok: vok=%b done=%b required 1 1", vok, done);
        end
        n_checks++;
        if (crc !== crc_ref(exp_vec())) begin
            n_fail++;
            $display("FAIL verify_crc: got %h required %h", crc, crc_ref(exp_vec()));
        end
        n_checks++;
        if (chain !== load_chain) begin
            n_fail++;
            $display("FAIL verify_chain_kept: got %b required %b", chain, load_chain);
        end
    endtask

    task automatic test_verify_flip();
        set_ref_bytes();
        flip_abs = sh_cnt + int'($urandom_range(0, CL - 1));
        flip_en  = 1'b1;
        run_pass(1'b1, -1, 0, 1'b0);
        flip_en  = 1'b0;
        n_checks++;
        if (vok !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL flip_verify_ok: vok=%b done=%b required 0 1", vok, done);
        end
        n_checks++;
        if (crc !== load_crc) begin
            n_fail++;
            $display("FAIL flip_crc: got %h required %h", crc, load_crc);
        end
    endtask

    task automatic test_stall();
        set_ref_bytes();
        run_pass(1'b0, 1, 10, 1'b0);
        n_checks++;
        if (q2v(head_q) !== load_head || head_q.size() != CL) begin
            n_fail++;
            $display("FAIL stall_head_seq: got %b (%0d bits) required %b", q2v(head_q), head_q.size(), load_head);
        end
        n_checks++;
        if (crc !== load_crc) begin
            n_fail++;
            $display("FAIL stall_crc: got %h required %h", crc, load_crc);
        end
    endtask

    task automatic test_start_during_shift();
        set_ref_bytes();
        run_pass(1'b0, -1, 0, 1'b1);
        n_checks++;
        if (head_q.size() != CL) begin
            n_fail++;
            $display("FAIL glitch_en_cycles: got %0d required %0d", head_q.size(), CL);
        end
        n_checks++;
        if (crc !== load_crc || q2v(head_q) !== load_head) begin
            n_fail++;
            $display("FAIL glitch_crc: got %h required %h", crc, load_crc);
        end
    endtask

    task automatic test_reset_mid_pass();
        int idx = 0;
        int cycles = 0;
        int base;
        int frozen;
        set_ref_bytes();
        base = sh_cnt;
        @(negedge clk);
        start = 1'b1;
        vfy   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!(en && sh_cnt == base + 4) && cycles < 200) begin
            s_valid = (idx < bytes.size());
            s_data  = s_valid ? bytes[idx] : 8'h00;
            if (s_ready && s_valid) idx++;
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (!(en && sh_cnt == base + 4)) begin
            n_fail++;
            $display("FAIL rst_reach_shift5: never reached 5th shift cycle");
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({s_ready, head, en, busy, done, vok, crc} !== {6'b0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL rst_mid_pass_outputs: got %b_%h required 000000_ffff",
                     {s_ready, head, en, busy, done, vok}, crc);
        end
        frozen = sh_cnt;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sh_cnt != frozen || en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_shift: shifts got %0d required %0d", sh_cnt, frozen);
        end
        s_valid = 1'b0;
        rst     = 1'b0;
        run_pass(1'b0, -1, 0, 1'b0);
        n_checks++;
        if (crc !== load_crc || chain !== exp_vec() || head_q.size() != CL) begin
            n_fail++;
            $display("FAIL rst_reload: crc got %h required %h, chain got %b required %b",
                     crc, load_crc, chain, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            bytes.delete();
            for (int b = 0; b < 3; b++) bytes.push_back(8'($urandom));
            run_pass(1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'b0);
            n_checks++;
            if (crc !== crc_ref(exp_vec()) || chain !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_load[%0d]: crc got %h required %h, chain got %b required %b",
                         r, crc, crc_ref(exp_vec()), chain, exp_vec());
            end
            run_pass(1'b1, -1, 0, 1'b0);
            n_checks++;
            if (vok !== 1'b1 || q2v(tail_q) !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_verify[%0d]: vok=%b tail %b required 1 %b", r, vok, q2v(tail_q), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_verify();
        test_verify_flip();
        test_stall();
        test_start_during_shift();
        test_reset_mid_pass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
